// File: rtl/ttl_multi_timed_output_if.sv
// ttl_multi_timed_output_if
//   Event bus between the event-decode/DMA path (master) and the timed TTL
//   output stage (slave). One event is transferred on every clock edge where
//   event_valid and event_ready are both high.
// Signals:
//   event_valid  master->slave  event present on the event_* lines
//   event_ready  slave->master  stage can accept an event this cycle
//   event_time   master->slave  timestamp at which the event fires
//   event_mask   master->slave  channels written by the event
//   event_value  master->slave  new level for the masked channels
//   event_pw     master->slave  pulse width in cycles, 0 = level event
interface ttl_multi_timed_output_if #(
  parameter int NUM_CH     = 8,
  parameter int TIME_WIDTH = 64,
  parameter int PW_WIDTH   = 16
);
  logic                  event_valid;
  logic                  event_ready;
  logic [TIME_WIDTH-1:0] event_time;
  logic [NUM_CH-1:0]     event_mask;
  logic [NUM_CH-1:0]     event_value;
  logic [PW_WIDTH-1:0]   event_pw;

  modport master (
    output event_valid, event_time, event_mask, event_value, event_pw,
    input  event_ready
  );

  modport slave (
    input  event_valid, event_time, event_mask, event_value, event_pw,
    output event_ready
  );
endinterface

// File: rtl/ttl_multi_timed_output.sv
// ttl_multi_timed_output
//   Multi-channel timed TTL output stage. Timestamped channel-update events are
//   queued in a FIFO; the head event is applied to a shadow register once the
//   global timestamp reaches its fire time (at most one event per cycle). The
//   registered outputs show either the shadow or a host override value.
//   Late fires and dropped pushes raise sticky error flags.
//
//   Optional feature macro TTL_PULSE_EN: when defined, events with a non-zero
//   pulse width hold the masked channels at the new level for exactly pw
//   cycles and then restore the previous levels. When undefined, event_pw is
//   ignored and every event is a level event.
//
// Ports:
//   clk             system clock
//   resetn          asynchronous active-low reset, released synchronously
//   timestamp       global time counter
//   evt             event bus (slave side of ttl_multi_timed_output_if)
//   override_en     force outputs to override_value
//   override_value  forced output levels
//   error_clear     one-cycle pulse clearing both sticky error flags
//   output_pulse    registered TTL outputs
//   overrided       registered copy of override_en
//   late_error      sticky: an event fired after its time
//   overflow_error  sticky: event_valid while the stage was not ready
//   fifo_count      current FIFO occupancy
module ttl_multi_timed_output #(
  parameter int NUM_CH     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIME_WIDTH = 64,
  parameter int PW_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [TIME_WIDTH-1:0]         timestamp,
  ttl_multi_timed_output_if.slave       evt,
  input  logic                          override_en,
  input  logic [NUM_CH-1:0]             override_value,
  input  logic                          error_clear,
  output logic [NUM_CH-1:0]             output_pulse,
  output logic                          overrided,
  output logic                          late_error,
  output logic                          overflow_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [TIME_WIDTH-1:0] fire_time;
    logic [NUM_CH-1:0]     mask;
    logic [NUM_CH-1:0]     value;
`ifdef TTL_PULSE_EN
    logic [PW_WIDTH-1:0]   pw;
`endif
  } event_t;

  event_t            mem [FIFO_DEPTH];
  event_t            head;
  event_t            wr_event;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              ready_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              fire;
  logic              late_set;
  logic              overflow_set;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] shadow_next;

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // ready_q holds event_ready low while in reset and for nothing else; it rises
  // on the first edge after release.
  assign evt.event_ready = ready_q & ~full;
  assign push            = evt.event_valid & evt.event_ready;
  assign overflow_set    = evt.event_valid & ~evt.event_ready;

  always_comb begin
    wr_event           = '0;
    wr_event.fire_time = evt.event_time;
    wr_event.mask      = evt.event_mask;
    wr_event.value     = evt.event_value;
`ifdef TTL_PULSE_EN
    wr_event.pw        = evt.event_pw;
`endif
  end

  // Head is read combinationally; an entry written at edge t is visible here
  // from cycle t+1 on, so a freshly pushed event can never fire in its push
  // cycle.
  assign head     = mem[rd_ptr];
  assign fire     = ~empty & (timestamp >= head.fire_time);
  assign late_set = fire & (timestamp > head.fire_time);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (fire) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only the pointers and count define
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_event;
  end

  assign fifo_count = count;

  // ---------------------------------------------------------------------------
  // Shadow update
  // ---------------------------------------------------------------------------
`ifdef TTL_PULSE_EN
  typedef enum logic {IDLE, PULSE} state_t;

  state_t              state;
  state_t              state_next;
  logic [PW_WIDTH-1:0] cnt;
  logic [PW_WIDTH-1:0] cnt_next;
  logic [NUM_CH-1:0]   restore_mask;
  logic [NUM_CH-1:0]   restore_mask_next;
  logic [NUM_CH-1:0]   restore_val;
  logic [NUM_CH-1:0]   restore_val_next;
  logic [NUM_CH-1:0]   base;
  logic                pulse_fire;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      restore_mask <= '0;
      restore_val  <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      restore_mask <= restore_mask_next;
      restore_val  <= restore_val_next;
    end
  end

  // base is the shadow after any pending restore; the firing event (if any)
  // is then layered on top so its bits win over the restored levels.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // a signal unassigned (which would infer a latch).
    state_next        = state;
    cnt_next          = cnt;
    restore_mask_next = restore_mask;
    restore_val_next  = restore_val;
    base              = shadow;
    pulse_fire        = fire & (head.pw != '0);

    if (state == PULSE) begin
      cnt_next = cnt - PW_WIDTH'(1);
      // A new pulse must be captured against the restored levels, so the
      // pending restore is applied early in that case.
      if ((cnt == PW_WIDTH'(1)) || pulse_fire) begin
        base       = (shadow & ~restore_mask) | (restore_val & restore_mask);
        state_next = IDLE;
      end else if (fire) begin
        // Level write mid-pulse: those channels now belong to the newer event.
        restore_mask_next = restore_mask & ~head.mask;
        if ((restore_mask & ~head.mask) == '0) state_next = IDLE;
      end
    end

    shadow_next = base;
    if (fire) shadow_next = (base & ~head.mask) | (head.value & head.mask);

    if (pulse_fire) begin
      restore_mask_next = head.mask;
      restore_val_next  = base & head.mask;
      cnt_next          = head.pw;
      state_next        = PULSE;
    end
  end
`else
  logic unused_pw;
  assign unused_pw = ^evt.event_pw;

  always_comb begin
    shadow_next = shadow;
    if (fire) shadow_next = (shadow & ~head.mask) | (head.value & head.mask);
  end
`endif

  // ---------------------------------------------------------------------------
  // Output and error registers
  // ---------------------------------------------------------------------------
  // output_pulse is loaded from shadow_next so a fire at edge F is visible on
  // the pins in the cycle right after F, in step with the shadow itself.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow         <= '0;
      output_pulse   <= '0;
      overrided      <= 1'b0;
      late_error     <= 1'b0;
      overflow_error <= 1'b0;
    end else begin
      shadow         <= shadow_next;
      output_pulse   <= override_en ? override_value : shadow_next;
      overrided      <= override_en;
      // Set wins over a simultaneous clear.
      late_error     <= late_set     | (late_error     & ~error_clear);
      overflow_error <= overflow_set | (overflow_error & ~error_clear);
    end
  end

endmodule

// File: tb/tb_ttl_multi_timed_output.sv
// tb_ttl_multi_timed_output
//   Self-checking bench for ttl_multi_timed_output with the default parameters.
//   Each scenario task drives the event bus and timestamp, records expected
//   output levels in a scoreboard queue when stimulus is applied, and pops and
//   compares them once the DUT has had its cycle to respond.
module tb_ttl_multi_timed_output;

  localparam int NUM_CH     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int TIME_WIDTH = 64;
  localparam int PW_WIDTH   = 16;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [TIME_WIDTH-1:0] timestamp;
  logic                  override_en;
  logic [NUM_CH-1:0]     override_value;
  logic                  error_clear;
  logic [NUM_CH-1:0]     output_pulse;
  logic                  overrided;
  logic                  late_error;
  logic                  overflow_error;
  logic [CW-1:0]         fifo_count;

  int errors = 0;
  int checks = 0;
  logic [NUM_CH-1:0] exp_q [$];

  ttl_multi_timed_output_if #(
    .NUM_CH(NUM_CH), .TIME_WIDTH(TIME_WIDTH), .PW_WIDTH(PW_WIDTH)
  ) evt ();

  ttl_multi_timed_output #(
    .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH),
    .TIME_WIDTH(TIME_WIDTH), .PW_WIDTH(PW_WIDTH)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .timestamp      (timestamp),
    .evt            (evt),
    .override_en    (override_en),
    .override_value (override_value),
    .error_clear    (error_clear),
    .output_pulse   (output_pulse),
    .overrided      (overrided),
    .late_error     (late_error),
    .overflow_error (overflow_error),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the
  // rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_event(input logic [TIME_WIDTH-1:0] t, input logic [NUM_CH-1:0] m,
                             input logic [NUM_CH-1:0] v, input logic [PW_WIDTH-1:0] pw);
    evt.event_valid = 1'b1;
    evt.event_time  = t;
    evt.event_mask  = m;
    evt.event_value = v;
    evt.event_pw    = pw;
  endtask

  task automatic idle_bus();
    evt.event_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn         = 1'b0;
    timestamp      = '0;
    override_en    = 1'b0;
    override_value = '0;
    error_clear    = 1'b0;
    evt.event_valid = 1'b0;
    evt.event_time  = '0;
    evt.event_mask  = '0;
    evt.event_value = '0;
    evt.event_pw    = '0;
    #12;
    checks++;
    if ({output_pulse, overrided, late_error, overflow_error, fifo_count, evt.event_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state: out=%h ovr=%b late=%b ovf=%b cnt=%0d rdy=%b required all zero",
               output_pulse, overrided, late_error, overflow_error, fifo_count, evt.event_ready);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    checks++;
    if (evt.event_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: event_ready=%b required 0", evt.event_ready);
    end
    tick();
    checks++;
    if (evt.event_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: event_ready=%b required 1", evt.event_ready);
    end
  endtask

  // Event at t=100 applied while timestamp sweeps 90..110.
  task automatic test_level_event();
    logic [NUM_CH-1:0] exp;
    timestamp = 64'd90;
    drive_event(64'd100, 8'h0F, 8'h05, 16'd0);
    tick();
    idle_bus();
    for (int ts = 91; ts <= 110; ts++) begin
      timestamp = 64'(ts);
      exp_q.push_back((ts >= 100) ? 8'h05 : 8'h00);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (output_pulse !== exp) begin
        errors++;
        $display("FAIL level_ts%0d: output_pulse=%h required %h", ts, output_pulse, exp);
      end
    end
    checks++;
    if (late_error !== 1'b0 || fifo_count !== CW'(0)) begin
      errors++;
      $display("FAIL level_on_time: late_error=%b fifo_count=%0d required 0 and 0", late_error, fifo_count);
    end
  endtask

  task automatic test_late_event();
    timestamp = 64'd500;
    drive_event(64'd200, 8'hFF, 8'hAA, 16'd0);
    tick();
    idle_bus();
    checks++;
    if (output_pulse !== 8'h05 || late_error !== 1'b0 || fifo_count !== CW'(1)) begin
      errors++;
      $display("FAIL late_push_cycle: out=%h late=%b cnt=%0d required 05 0 1", output_pulse, late_error, fifo_count);
    end
    tick();
    checks++;
    if (output_pulse !== 8'hAA || late_error !== 1'b1 || fifo_count !== CW'(0)) begin
      errors++;
      $display("FAIL late_fire: out=%h late=%b cnt=%0d required AA 1 0", output_pulse, late_error, fifo_count);
    end
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    checks++;
    if (late_error !== 1'b0) begin
      errors++;
      $display("FAIL late_clear: late_error=%b required 0", late_error);
    end
  endtask

  task automatic test_overflow();
    timestamp = 64'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      drive_event(64'd1000, 8'hFF, 8'(i), 16'd0);
      tick();
    end
    checks++;
    if (evt.event_ready !== 1'b0 || fifo_count !== CW'(FIFO_DEPTH)) begin
      errors++;
      $display("FAIL full: event_ready=%b fifo_count=%0d required 0 16", evt.event_ready, fifo_count);
    end
    drive_event(64'd1000, 8'hFF, 8'h5A, 16'd0);
    tick();
    checks++;
    if (overflow_error !== 1'b1 || fifo_count !== CW'(FIFO_DEPTH)) begin
      errors++;
      $display("FAIL overflow_push: overflow_error=%b fifo_count=%0d required 1 16", overflow_error, fifo_count);
    end
    // Refused push in the same cycle as a clear: the set must win.
    error_clear = 1'b1;
    tick();
    checks++;
    if (overflow_error !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set_wins: overflow_error=%b required 1", overflow_error);
    end
    idle_bus();
    tick();
    error_clear = 1'b0;
    checks++;
    if (overflow_error !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: overflow_error=%b required 0", overflow_error);
    end
    // Drain: one event per cycle, oldest first; timestamp equals fire time.
    timestamp = 64'd1000;
    for (int k = 1; k <= FIFO_DEPTH; k++) begin
      tick();
      checks++;
      if (fifo_count !== CW'(FIFO_DEPTH - k) || output_pulse !== 8'(k - 1)) begin
        errors++;
        $display("FAIL drain_%0d: fifo_count=%0d out=%h required %0d %h",
                 k, fifo_count, output_pulse, FIFO_DEPTH - k, 8'(k - 1));
      end
    end
    checks++;
    if (late_error !== 1'b0 || evt.event_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: late_error=%b event_ready=%b required 0 1", late_error, evt.event_ready);
    end
  endtask

  task automatic test_override();
    override_en    = 1'b1;
    override_value = 8'hF0;
    tick();
    checks++;
    if (output_pulse !== 8'hF0 || overrided !== 1'b1) begin
      errors++;
      $display("FAIL override_on: out=%h overrided=%b required F0 1", output_pulse, overrided);
    end
    drive_event(64'd1000, 8'hFF, 8'h33, 16'd0);
    tick();
    idle_bus();
    tick();
    checks++;
    if (output_pulse !== 8'hF0 || fifo_count !== CW'(0)) begin
      errors++;
      $display("FAIL override_hold: out=%h fifo_count=%0d required F0 0", output_pulse, fifo_count);
    end
    override_en = 1'b0;
    tick();
    checks++;
    if (output_pulse !== 8'h33 || overrided !== 1'b0) begin
      errors++;
      $display("FAIL override_release: out=%h overrided=%b required 33 0", output_pulse, overrided);
    end
  endtask

  // Valid held for four cycles: one push and one pop per cycle, count steady.
  task automatic test_back_to_back();
    logic [NUM_CH-1:0] vals [4];
    logic [NUM_CH-1:0] exp;
    vals = '{8'h11, 8'h22, 8'h44, 8'h88};
    timestamp = 64'd1000;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        drive_event(64'd1000, 8'hFF, vals[k], 16'd0);
        exp_q.push_back(vals[k]);
      end else begin
        idle_bus();
      end
      tick();
      checks++;
      if (fifo_count !== CW'((k < 4) ? 1 : 0)) begin
        errors++;
        $display("FAIL b2b_count_%0d: fifo_count=%0d required %0d", k, fifo_count, (k < 4) ? 1 : 0);
      end
      if (k >= 1) begin
        exp = exp_q.pop_front();
        checks++;
        if (output_pulse !== exp) begin
          errors++;
          $display("FAIL b2b_out_%0d: output_pulse=%h required %h", k, output_pulse, exp);
        end
      end
    end
  endtask

`ifdef TTL_PULSE_EN
  task automatic test_pulse();
    logic [NUM_CH-1:0] exp;
    timestamp = 64'd1000;
    drive_event(64'd1000, 8'hFF, 8'h00, 16'd0);
    tick();
    idle_bus();
    tick();
    drive_event(64'd1000, 8'h01, 8'h01, 16'd4);
    tick();
    idle_bus();
    for (int c = 0; c < 6; c++) begin
      exp_q.push_back((c < 4) ? 8'h01 : 8'h00);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (output_pulse !== exp) begin
        errors++;
        $display("FAIL pulse_c%0d: output_pulse=%h required %h", c, output_pulse, exp);
      end
    end
    // Level write to the same channel during the pulse cancels its restore.
    drive_event(64'd1000, 8'h01, 8'h01, 16'd4);
    tick();
    drive_event(64'd1000, 8'h01, 8'h01, 16'd0);
    tick();
    idle_bus();
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if (output_pulse !== 8'h01) begin
        errors++;
        $display("FAIL pulse_level_c%0d: output_pulse=%h required 01", c, output_pulse);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_run();
    timestamp = 64'd1000;
`ifdef TTL_PULSE_EN
    drive_event(64'd1000, 8'hFF, 8'hFF, 16'd50);
    tick();
    idle_bus();
    tick();
`endif
    for (int i = 0; i < 5; i++) begin
      drive_event(64'd5000, 8'hFF, 8'(i + 1), 16'd0);
      tick();
    end
    idle_bus();
    checks++;
    if (fifo_count !== CW'(5) || output_pulse === 8'h00) begin
      errors++;
      $display("FAIL pre_reset: fifo_count=%0d out=%h required 5 and nonzero", fifo_count, output_pulse);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({output_pulse, overrided, late_error, overflow_error, fifo_count, evt.event_ready} !== '0) begin
      errors++;
      $display("FAIL async_reset: out=%h ovr=%b late=%b ovf=%b cnt=%0d rdy=%b required all zero",
               output_pulse, overrided, late_error, overflow_error, fifo_count, evt.event_ready);
    end
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    timestamp = 64'd6000;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (output_pulse !== 8'h00 || fifo_count !== CW'(0) || late_error !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_c%0d: out=%h cnt=%0d late=%b required 00 0 0",
                 c, output_pulse, fifo_count, late_error);
      end
    end
    checks++;
    if (evt.event_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: event_ready=%b required 1", evt.event_ready);
    end
  endtask

  initial begin
    test_reset();
    test_level_event();
    test_late_event();
    test_overflow();
    test_override();
    test_back_to_back();
`ifdef TTL_PULSE_EN
    test_pulse();
`endif
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
